// File: rtl/gpio_pwm_pkg.sv
// gpio_pwm_pkg: shared key indices, breathe states and sizing helpers for gpio_pwm_multich.
// The breathe state type is only used when GPIO_PWM_BREATHE_EN is defined.
package gpio_pwm_pkg;
   localparam int KEY_UP  = 0;
   localparam int KEY_DN  = 1;
   localparam int KEY_SEL = 2;

   typedef enum logic [1:0] {BR_OFF, BR_UP, BR_DN} br_state_e;

   function automatic int CH_IDX_W(input int ch_num);
      return (ch_num > 2) ? $clog2(ch_num) : 1;
   endfunction

   function automatic int PH_OFS(input int i, input int ch_num, input int duty_w);
      return i * ((1 << duty_w) / ch_num);
   endfunction
endpackage

// File: rtl/gpio_pwm_channel.sv
// gpio_pwm_channel: one PWM lane with shadow/active duty, phase-offset compare and registered output.
// Breathing ramp and its FSM exist only when GPIO_PWM_BREATHE_EN is defined.
module gpio_pwm_channel
   import gpio_pwm_pkg::*;
#(
   parameter int DUTY_W    = 8,
   parameter int DUTY_STEP = 16,
   parameter int DUTY_INIT = 128,
   parameter int PH_OFFSET = 0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wrap_i,
   input  logic              en_i,
   input  logic [DUTY_W-1:0] phase_i,
   input  logic              inc_i,
   input  logic              dec_i,
`ifdef GPIO_PWM_BREATHE_EN
   input  logic              brk_toggle_i,
`endif
   output logic              pwm_o,
   output logic [DUTY_W:0]   shadow_o
);
   localparam logic [DUTY_W:0]   MAX_D  = {1'b1, {DUTY_W{1'b0}}};
   localparam logic [DUTY_W:0]   STEP   = (DUTY_W+1)'(DUTY_STEP);
   localparam logic [DUTY_W:0]   INIT   = (DUTY_W+1)'(DUTY_INIT);
   localparam logic [DUTY_W:0]   ONE    = (DUTY_W+1)'(1);
   localparam logic [DUTY_W-1:0] OFS    = DUTY_W'(PH_OFFSET);

   logic [DUTY_W:0]   shadow_q, shadow_d, active_q, active_d, man_d;
   logic [DUTY_W-1:0] ph;
   logic              pwm_q, pwm_d;

   always_comb begin
      ph       = phase_i + OFS;
      man_d    = inc_i ? ((shadow_q > MAX_D - STEP) ? MAX_D : shadow_q + STEP)
               : dec_i ? ((shadow_q < STEP) ? '0 : shadow_q - STEP)
               : shadow_q;
      // While disabled the active duty tracks the shadow so a restart uses the latest value
      active_d = (!en_i || wrap_i) ? shadow_q : active_q;
      pwm_d    = en_i && ({1'b0, ph} < active_q);
   end

`ifdef GPIO_PWM_BREATHE_EN
   br_state_e br_q;

   assign shadow_d = (br_q == BR_OFF) ? man_d
                   : (wrap_i && !brk_toggle_i) ? ((br_q == BR_UP) ? shadow_q + ONE : shadow_q - ONE)
                   : shadow_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         br_q <= BR_OFF;
      else if (brk_toggle_i)
         br_q <= (br_q != BR_OFF) ? BR_OFF : (shadow_q == MAX_D) ? BR_DN : BR_UP;
      else if (wrap_i && br_q == BR_UP && shadow_q == MAX_D - ONE)
         br_q <= BR_DN;
      else if (wrap_i && br_q == BR_DN && shadow_q == ONE)
         br_q <= BR_UP;
   end
`else
   assign shadow_d = man_d;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shadow_q <= INIT;
         active_q <= INIT;
         pwm_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         pwm_q    <= pwm_d;
      end
   end

   assign pwm_o    = pwm_q;
   assign shadow_o = shadow_q;
endmodule

// File: rtl/gpio_pwm_multich.sv
// gpio_pwm_multich: multi-channel PWM from a shared DDS accumulator with key-driven duty and channel select.
// Define GPIO_PWM_BREATHE_EN to let up+down together toggle per-channel breathing.
module gpio_pwm_multich
   import gpio_pwm_pkg::*;
#(
   parameter int               CH_NUM     = 4,
   parameter int               ACC_W      = 32,
   parameter logic [ACC_W-1:0] DEVICE_CNT = ACC_W'(85899),
   parameter int               DUTY_W     = 8,
   parameter int               DUTY_STEP  = 16,
   parameter int               DUTY_INIT  = 128
) (
   input  logic                          CLOCK,
   input  logic                          RST_n,
   input  logic                          En_Sig,
   input  logic [2:0]                    Option_Key,
   output logic [CH_NUM-1:0]             GPIO_PWM,
   output logic [CH_IDX_W(CH_NUM)-1:0]   Cur_Ch,
   output logic [DUTY_W:0]               Cur_Duty
);
   localparam int            CW      = CH_IDX_W(CH_NUM);
   localparam logic [CW-1:0] CH_LAST = CW'(CH_NUM - 1);

   logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
   logic             carry, wrap;
   logic [2:0]       key_q, rise;
   logic [CW-1:0]    ch_q, ch_d;
   logic             sel, up, dn;
   logic [DUTY_W:0]  shadow [CH_NUM];

   always_comb begin
      {carry, acc_sum} = {1'b0, acc_q} + {1'b0, DEVICE_CNT};
      wrap  = En_Sig && carry;
      acc_d = En_Sig ? acc_sum : '0;
      rise  = Option_Key & ~key_q;
      // Channel advance wins; up and down together cancel each other for manual stepping
      sel   = rise[KEY_SEL];
      up    = rise[KEY_UP] && !rise[KEY_DN] && !sel;
      dn    = rise[KEY_DN] && !rise[KEY_UP] && !sel;
      ch_d  = sel ? ((ch_q == CH_LAST) ? '0 : ch_q + 1'b1) : ch_q;
   end

`ifdef GPIO_PWM_BREATHE_EN
   logic tog;
   assign tog = rise[KEY_UP] && rise[KEY_DN] && !sel;
`endif

   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n) begin
         acc_q <= '0;
         key_q <= '0;
         ch_q  <= '0;
      end else begin
         acc_q <= acc_d;
         key_q <= Option_Key;
         ch_q  <= ch_d;
      end
   end

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      gpio_pwm_channel #(
         .DUTY_W   (DUTY_W),
         .DUTY_STEP(DUTY_STEP),
         .DUTY_INIT(DUTY_INIT),
         .PH_OFFSET(PH_OFS(i, CH_NUM, DUTY_W))
      ) u_ch (
         .clk_i       (CLOCK),
         .rst_ni      (RST_n),
         .wrap_i      (wrap),
         .en_i        (En_Sig),
         .phase_i     (acc_q[ACC_W-1 -: DUTY_W]),
         .inc_i       (up && ch_q == CW'(i)),
         .dec_i       (dn && ch_q == CW'(i)),
`ifdef GPIO_PWM_BREATHE_EN
         .brk_toggle_i(tog && ch_q == CW'(i)),
`endif
         .pwm_o       (GPIO_PWM[i]),
         .shadow_o    (shadow[i])
      );
   end

   assign Cur_Ch   = ch_q;
   assign Cur_Duty = shadow[ch_q];
endmodule

// File: tb/tb_gpio_pwm_multich.sv
// tb_gpio_pwm_multich: scoreboard bench for gpio_pwm_multich with a 256-cycle PWM period.
// Breathing checks are built only when GPIO_PWM_BREATHE_EN is defined.
module tb_gpio_pwm_multich;
   localparam int CH   = 4;
   localparam int DW   = 8;
   localparam int MAXD = 256;
   localparam int STEP = 16;

   logic          CLOCK = 1'b0;
   logic          RST_n = 1'b0;
   logic          En_Sig = 1'b0;
   logic [2:0]    Option_Key = '0;
   logic [CH-1:0] GPIO_PWM;
   logic [1:0]    Cur_Ch;
   logic [DW:0]   Cur_Duty;

   gpio_pwm_multich #(
      .CH_NUM(CH), .ACC_W(16), .DEVICE_CNT(16'd256),
      .DUTY_W(DW), .DUTY_STEP(STEP), .DUTY_INIT(128)
   ) dut (
      .CLOCK(CLOCK), .RST_n(RST_n), .En_Sig(En_Sig), .Option_Key(Option_Key),
      .GPIO_PWM(GPIO_PWM), .Cur_Ch(Cur_Ch), .Cur_Duty(Cur_Duty)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct {int ch; int highs; int rise;} exp_t;
   exp_t sb[$];
   int n_chk = 0, n_fail = 0, kc = 0, exp_ch = 0;
   int exp_sh[CH], exp_act[CH];

   task automatic tick();
      @(negedge CLOCK);
      kc++;
   endtask

   // Stops on the sample that follows a wrap, so the next tick starts a fresh period
   task automatic align();
      do tick(); while (kc % 256 != 255);
   endtask

   task automatic press(input logic [2:0] v);
      Option_Key = v;
      tick();
      Option_Key = '0;
      tick();
      if (v[2]) exp_ch = (exp_ch + 1) % CH;
      else if (v[0] && !v[1]) exp_sh[exp_ch] = (exp_sh[exp_ch] + STEP > MAXD) ? MAXD : exp_sh[exp_ch] + STEP;
      else if (v[1] && !v[0]) exp_sh[exp_ch] = (exp_sh[exp_ch] < STEP) ? 0 : exp_sh[exp_ch] - STEP;
   endtask

   task automatic settle();
      repeat (260) tick();
      align();
      for (int i = 0; i < CH; i++) exp_act[i] = exp_sh[i];
   endtask

   function automatic int exp_rise(input int i, input int a);
      return (a == 0 || a == MAXD) ? -1 : (MAXD - i * (MAXD / CH)) % MAXD;
   endfunction

   task automatic push_exp();
      for (int i = 0; i < CH; i++) sb.push_back('{i, exp_act[i], exp_rise(i, exp_act[i])});
   endtask

   // Measures one full period and checks it against the queued expectations
   task automatic window(input int press_at, input logic [2:0] pv, output logic [DW:0] duty_seen);
      int highs[CH], rise[CH];
      logic [CH-1:0] prev;
      exp_t e;
      prev = GPIO_PWM;
      duty_seen = Cur_Duty;
      for (int i = 0; i < CH; i++) begin highs[i] = 0; rise[i] = -1; end
      for (int j = 0; j < 256; j++) begin
         tick();
         if (j == press_at) Option_Key = pv;
         if (j == press_at + 1) begin Option_Key = '0; duty_seen = Cur_Duty; end
         for (int i = 0; i < CH; i++) begin
            if (GPIO_PWM[i]) highs[i]++;
            if (!prev[i] && GPIO_PWM[i] && rise[i] < 0) rise[i] = j;
         end
         prev = GPIO_PWM;
      end
      for (int i = 0; i < CH; i++) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries want %0d", CH - i);
         end else begin
            e = sb.pop_front();
            if (highs[e.ch] !== e.highs || rise[e.ch] !== e.rise) begin
               n_fail++;
               $display("FAIL window ch%0d: got highs=%0d rise=%0d want highs=%0d rise=%0d",
                        e.ch, highs[e.ch], rise[e.ch], e.highs, e.rise);
            end
         end
      end
   endtask

   task automatic do_reset();
      RST_n = 1'b0; En_Sig = 1'b0; Option_Key = '0;
      repeat (3) tick();
      RST_n = 1'b1;
      tick();
      En_Sig = 1'b1;
      kc = -1;
      exp_ch = 0;
      for (int i = 0; i < CH; i++) begin exp_sh[i] = 128; exp_act[i] = 128; end
   endtask

   task automatic test_reset();
      logic [DW:0] d;
      RST_n = 1'b0; En_Sig = 1'b0;
      repeat (3) tick();
      n_chk++;
      if (GPIO_PWM !== 4'b0000 || Cur_Ch !== 2'd0 || Cur_Duty !== 9'd128) begin
         n_fail++;
         $display("FAIL reset_state: got pwm=%b ch=%0d duty=%0d want pwm=0000 ch=0 duty=128", GPIO_PWM, Cur_Ch, Cur_Duty);
      end
      do_reset();
      align();
      push_exp();
      window(-1, 3'b000, d);
      n_chk++;
      if (d !== 9'd128) begin n_fail++; $display("FAIL reset_duty: got %0d want 128", d); end
   endtask

   task automatic test_duty_step();
      logic [DW:0] d;
      push_exp();
      window(100, 3'b001, d);
      exp_sh[0] = 144;
      n_chk++;
      if (d !== 9'd144) begin n_fail++; $display("FAIL step_next_cycle: got %0d want 144", d); end
      for (int i = 0; i < CH; i++) exp_act[i] = exp_sh[i];
      push_exp();
      window(-1, 3'b000, d);
   endtask

   task automatic test_saturate();
      logic [DW:0] d;
      do_reset();
      for (int n = 1; n <= 9; n++) begin
         press(3'b001);
         n_chk++;
         if (Cur_Duty !== 9'((128 + n * STEP > MAXD) ? MAXD : 128 + n * STEP)) begin
            n_fail++;
            $display("FAIL sat_up press %0d: got %0d want %0d", n, Cur_Duty, (128 + n * STEP > MAXD) ? MAXD : 128 + n * STEP);
         end
      end
      settle();
      push_exp();
      window(-1, 3'b000, d);
      for (int n = 1; n <= 17; n++) begin
         press(3'b010);
         n_chk++;
         if (Cur_Duty !== 9'((MAXD - n * STEP < 0) ? 0 : MAXD - n * STEP)) begin
            n_fail++;
            $display("FAIL sat_dn press %0d: got %0d want %0d", n, Cur_Duty, (MAXD - n * STEP < 0) ? 0 : MAXD - n * STEP);
         end
      end
      settle();
      push_exp();
      window(-1, 3'b000, d);
   endtask

   task automatic test_channel_select();
      logic [DW:0] d;
      for (int n = 1; n <= 4; n++) begin
         press(3'b100);
         n_chk++;
         if (Cur_Ch !== 2'(n % CH)) begin n_fail++; $display("FAIL ch_sel %0d: got %0d want %0d", n, Cur_Ch, n % CH); end
      end
      press(3'b101);
      n_chk++;
      if (Cur_Ch !== 2'd1 || Cur_Duty !== 9'd128) begin
         n_fail++;
         $display("FAIL sel_beats_up: got ch=%0d duty=%0d want ch=1 duty=128", Cur_Ch, Cur_Duty);
      end
      press(3'b001);
      n_chk++;
      if (Cur_Duty !== 9'd144) begin n_fail++; $display("FAIL ch1_up: got %0d want 144", Cur_Duty); end
`ifndef GPIO_PWM_BREATHE_EN
      press(3'b011);
      n_chk++;
      if (Cur_Duty !== 9'd144) begin n_fail++; $display("FAIL up_dn_ignored: got %0d want 144", Cur_Duty); end
`endif
      repeat (3) press(3'b100);
      n_chk++;
      if (Cur_Ch !== 2'd0 || Cur_Duty !== 9'd0) begin
         n_fail++;
         $display("FAIL ch_back: got ch=%0d duty=%0d want ch=0 duty=0", Cur_Ch, Cur_Duty);
      end
      settle();
      push_exp();
      window(-1, 3'b000, d);
   endtask

   task automatic test_enable();
      logic [DW:0] d;
      int bad;
      do_reset();
      press(3'b100);
      press(3'b001);
      align();
      repeat (100) tick();
      En_Sig = 1'b0;
      bad = 0;
      for (int n = 0; n < 100; n++) begin
         tick();
         n_chk++;
         if (GPIO_PWM !== 4'b0000) begin
            n_fail++;
            if (bad++ < 3) $display("FAIL disabled_out cycle %0d: got %b want 0000", n, GPIO_PWM);
         end
      end
      for (int i = 0; i < CH; i++) exp_act[i] = exp_sh[i];
      En_Sig = 1'b1;
      kc = -1;
      tick();
      n_chk++;
      if (GPIO_PWM !== 4'b0011) begin n_fail++; $display("FAIL restart_first: got %b want 0011", GPIO_PWM); end
      align();
      push_exp();
      window(-1, 3'b000, d);
      repeat (50) tick();
      n_chk++;
      if (GPIO_PWM[0] !== 1'b1 || Cur_Ch !== 2'd1) begin
         n_fail++;
         $display("FAIL pre_rst: got pwm0=%b ch=%0d want pwm0=1 ch=1", GPIO_PWM[0], Cur_Ch);
      end
      @(posedge CLOCK);
      #2 RST_n = 1'b0;
      #1;
      n_chk++;
      if (GPIO_PWM !== 4'b0000 || Cur_Ch !== 2'd0 || Cur_Duty !== 9'd128) begin
         n_fail++;
         $display("FAIL async_rst: got pwm=%b ch=%0d duty=%0d want pwm=0000 ch=0 duty=128", GPIO_PWM, Cur_Ch, Cur_Duty);
      end
      @(negedge CLOCK);
      RST_n = 1'b1;
   endtask

`ifdef GPIO_PWM_BREATHE_EN
   task automatic test_breathe();
      int b;
      bit up;
      do_reset();
      repeat (7) press(3'b001);
      align();
      tick();
      press(3'b011);
      Option_Key = 3'b001;
      tick();
      Option_Key = '0;
      tick();
      n_chk++;
      if (Cur_Duty !== 9'd240) begin n_fail++; $display("FAIL brth_manual_ignored: got %0d want 240", Cur_Duty); end
      b = 240;
      up = 1'b1;
      for (int w = 0; w < 274; w++) begin
         align();
         if (up) begin b++; if (b == MAXD) up = 1'b0; end
         else begin b--; if (b == 0) up = 1'b1; end
         n_chk++;
         if (Cur_Duty !== 9'(b)) begin n_fail++; $display("FAIL brth_wrap %0d: got %0d want %0d", w, Cur_Duty, b); end
      end
      press(3'b011);
      align();
      align();
      n_chk++;
      if (Cur_Duty !== 9'(b)) begin n_fail++; $display("FAIL brth_freeze: got %0d want %0d", Cur_Duty, b); end
   endtask
`endif

   initial begin
      test_reset();
      test_duty_step();
      test_saturate();
      test_channel_select();
      test_enable();
`ifdef GPIO_PWM_BREATHE_EN
      test_breathe();
`endif
      n_chk++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
